// File: rtl/vram_bus_arbiter_if.sv
// Signal bundle between the CPU core, the video DMA master, the SRAM and vram_bus_arbiter.
// The arbiter uses the slave view; the master view is the surrounding system.
interface vram_bus_arbiter_if;
  logic        hold;
  logic        vramcs;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic [7:0]  dma_rdata;
  logic        hold_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_vma;
  logic        cpu_ba;
  logic        cpu_halt;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic        mem_ce;
  logic        dma_err;

  modport slave (
    input  hold, vramcs, dma_addr, dma_wdata, dma_we,
    input  cpu_addr, cpu_wdata, cpu_rw, cpu_vma, cpu_ba,
    input  mem_rdata,
    output dma_rdata, hold_ack, cpu_halt, cpu_rdata,
    output mem_addr, mem_wdata, mem_we, mem_ce, dma_err
  );

  modport master (
    output hold, vramcs, dma_addr, dma_wdata, dma_we,
    output cpu_addr, cpu_wdata, cpu_rw, cpu_vma, cpu_ba,
    output mem_rdata,
    input  dma_rdata, hold_ack, cpu_halt, cpu_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_ce, dma_err
  );
endinterface

// File: rtl/vram_bus_arbiter.sv
// Hands the shared 64 KB SRAM bus between the CPU and the video DMA master by halting
// the CPU, then steers address, data and strobes through a registered select.
module vram_bus_arbiter #(
  parameter int unsigned BA_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  vram_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HALT_REQ = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] wait_cnt;
  logic [2:0] wait_cnt_nxt;
  logic       mux_dma;
  logic       dma_err_q;
  logic       timeout_hit;

  // The grant fires on the edge where the count would reach BA_TIMEOUT, so the CPU gets
  // exactly BA_TIMEOUT HALT_REQ cycles; the counter saturates at 7, so BA_TIMEOUT must be <= 8.
  assign timeout_hit = ({29'd0, wait_cnt} + 32'd1) >= BA_TIMEOUT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      mux_dma   <= 1'b0;
      dma_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mux_dma   <= (state_nxt == GRANT);
      dma_err_q <= dma_err_q | (bus.vramcs & (state != GRANT));
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus.cpu_halt = 1'b0;
    bus.hold_ack = 1'b0;
    case (state)
      IDLE: begin
        if (bus.hold) begin
          state_nxt    = HALT_REQ;
          wait_cnt_nxt = 3'd0;
        end
      end
      HALT_REQ: begin
        bus.cpu_halt = 1'b1;
        if (wait_cnt != 3'd7) wait_cnt_nxt = wait_cnt + 3'd1;
        if (!bus.hold)                        state_nxt = RELEASE;
        else if (bus.cpu_ba || timeout_hit)   state_nxt = GRANT;
      end
      GRANT: begin
        bus.cpu_halt = 1'b1;
        bus.hold_ack = 1'b1;
        if (!bus.hold) state_nxt = RELEASE;
      end
      RELEASE: begin
        bus.cpu_halt = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated with rst so a CPU access cannot reach the SRAM while reset is held.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_ce    = bus.cpu_vma & rst;
    bus.mem_we    = bus.cpu_vma & ~bus.cpu_rw & rst;
    bus.cpu_rdata = bus.mem_rdata;
    bus.dma_rdata = 8'hFF;
    if (mux_dma) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_ce    = bus.vramcs & rst;
      bus.mem_we    = bus.vramcs & bus.dma_we & rst;
      bus.cpu_rdata = 8'hFF;
      bus.dma_rdata = bus.mem_rdata;
    end
  end

  assign bus.dma_err = dma_err_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Randomised bench for vram_bus_arbiter: an SRAM model plus a cycle-level reference of the
// bus ownership rules predicts every output each cycle.
module tb_vram_bus_arbiter;

  localparam int BA_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;

  vram_bus_arbiter_if bus ();

  vram_bus_arbiter #(.BA_TIMEOUT(BA_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  assign bus.mem_rdata = sram[bus.mem_addr];

  int compared   = 0;
  int mismatched = 0;

  // Reference: who owns the bus, whether the CPU is held, and how long the DMA has waited.
  bit m_dma_owns;
  bit m_halted;
  bit m_releasing;
  bit m_err;
  int m_wait;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_dma_owns  = 1'b0;
    m_halted    = 1'b0;
    m_releasing = 1'b0;
    m_err       = 1'b0;
    m_wait      = -1;
  endfunction

  function automatic void model_step();
    if (bus.vramcs && !m_dma_owns) m_err = 1'b1;
    if (m_releasing) begin
      m_releasing = 1'b0;
      m_halted    = 1'b0;
    end else if (m_dma_owns) begin
      if (!bus.hold) begin
        m_dma_owns  = 1'b0;
        m_releasing = 1'b1;
      end
    end else if (m_wait >= 0) begin
      if (!bus.hold) begin
        m_wait      = -1;
        m_releasing = 1'b1;
      end else if (bus.cpu_ba || (m_wait + 1 >= BA_TIMEOUT)) begin
        m_wait     = -1;
        m_dma_owns = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (bus.hold) begin
      m_wait   = 0;
      m_halted = 1'b1;
    end
  endfunction

  // One clock: check outputs on the falling edge, then update SRAM and reference on the rising edge.
  task automatic applyStimulus();
    logic        sel;
    logic [15:0] e_addr;
    logic        e_ce;
    logic        e_we;
    logic [7:0]  e_wdata;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;
    @(negedge clk);
    sel     = m_dma_owns;
    e_addr  = sel ? bus.dma_addr : bus.cpu_addr;
    e_ce    = sel ? bus.vramcs : bus.cpu_vma;
    e_we    = sel ? (bus.vramcs & bus.dma_we) : (bus.cpu_vma & ~bus.cpu_rw);
    e_wdata = sel ? bus.dma_wdata : bus.cpu_wdata;
    checkOutput("hold_ack", bus.hold_ack, m_dma_owns);
    checkOutput("cpu_halt", bus.cpu_halt, m_halted);
    checkOutput("dma_err", bus.dma_err, m_err);
    checkOutput("mem_addr", bus.mem_addr, e_addr);
    checkOutput("mem_ce", bus.mem_ce, e_ce);
    checkOutput("mem_we", bus.mem_we, e_we);
    if (e_we) checkOutput("mem_wdata", bus.mem_wdata, e_wdata);
    checkOutput("dma_rdata", bus.dma_rdata, sel ? ref_mem[bus.dma_addr] : 8'hFF);
    checkOutput("cpu_rdata", bus.cpu_rdata, sel ? 8'hFF : ref_mem[bus.cpu_addr]);
    cap_we    = bus.mem_we;
    cap_addr  = bus.mem_addr;
    cap_wdata = bus.mem_wdata;
    @(posedge clk);
    if (cap_we === 1'b1) sram[cap_addr] = cap_wdata;
    if (e_we) ref_mem[e_addr] = e_wdata;
    model_step();
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) begin
      a          = i[15:0];
      sram[i]    = a[7:0];
      ref_mem[i] = a[7:0];
    end

    rst           = 1'b0;
    bus.hold      = 1'b0;
    bus.vramcs    = 1'b0;
    bus.dma_addr  = 16'h0000;
    bus.dma_wdata = 8'h00;
    bus.dma_we    = 1'b0;
    bus.cpu_addr  = 16'h0010;
    bus.cpu_wdata = 8'h3C;
    bus.cpu_rw    = 1'b0;
    bus.cpu_vma   = 1'b1;
    bus.cpu_ba    = 1'b0;
    model_reset();

    // Reset state, with a CPU write attempt held against the gated strobes
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_ack", bus.hold_ack, 1'b0);
    checkOutput("rst_cpu_halt", bus.cpu_halt, 1'b0);
    checkOutput("rst_dma_err", bus.dma_err, 1'b0);
    checkOutput("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_ce", bus.mem_ce, 1'b0);
    checkOutput("rst_dma_rdata", bus.dma_rdata, 8'hFF);
    rst         = 1'b1;
    bus.cpu_vma = 1'b0;
    bus.cpu_rw  = 1'b1;

    // Basic grant with a CPU that halts as soon as asked
    bus.dma_addr = 16'h4000;
    bus.hold     = 1'b1;
    lat = 0;
    do begin
      bus.cpu_ba = m_halted;
      applyStimulus();
      lat++;
    end while (bus.hold_ack !== 1'b1 && lat < 20);
    checkOutput("grant_latency", lat, 2);
    bus.vramcs = 1'b1;
    applyStimulus();
    checkOutput("grant_mem_addr", bus.mem_addr, 16'h4000);

    // 64-read DMA burst over the preloaded pattern
    for (int k = 0; k < 64; k++) begin
      a            = 16'($urandom);
      bus.dma_addr = a;
      applyStimulus();
      checkOutput("burst_rdata", bus.dma_rdata, a[7:0]);
    end
    bus.vramcs = 1'b0;
    checkOutput("burst_dma_err", bus.dma_err, 1'b0);

    // Release back to the CPU
    bus.hold = 1'b0;
    lat = 0;
    do begin
      bus.cpu_ba = m_halted;
      applyStimulus();
      lat++;
    end while (bus.cpu_halt !== 1'b0 && lat < 20);
    checkOutput("release_latency", lat, 2);
    bus.cpu_ba = 1'b0;

    // CPU write then read-back
    bus.cpu_addr  = 16'h1234;
    bus.cpu_wdata = 8'hA5;
    bus.cpu_rw    = 1'b0;
    bus.cpu_vma   = 1'b1;
    applyStimulus();
    checkOutput("cpu_wr_we", bus.mem_we, 1'b1);
    checkOutput("cpu_wr_addr", bus.mem_addr, 16'h1234);
    checkOutput("cpu_wr_data", bus.mem_wdata, 8'hA5);
    bus.cpu_rw = 1'b1;
    applyStimulus();
    checkOutput("cpu_rd_data", bus.cpu_rdata, 8'hA5);
    bus.cpu_vma = 1'b0;

    // Forced grant when the CPU never reports bus available
    bus.hold = 1'b1;
    lat = 0;
    do begin
      applyStimulus();
      lat++;
    end while (bus.hold_ack !== 1'b1 && lat < 20);
    checkOutput("timeout_latency", lat, BA_TIMEOUT + 1);
    bus.hold = 1'b0;
    repeat (3) applyStimulus();

    // DMA access while the halt is still pending
    bus.hold = 1'b1;
    applyStimulus();
    bus.vramcs    = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_wdata = 8'h77;
    bus.dma_addr  = 16'h4000;
    applyStimulus();
    checkOutput("early_rdata", bus.dma_rdata, 8'hFF);
    checkOutput("early_mem_ce", bus.mem_ce, 1'b0);
    checkOutput("early_err", bus.dma_err, 1'b1);
    bus.vramcs = 1'b0;
    bus.dma_we = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("early_err_sticky", bus.dma_err, 1'b1);
    bus.hold = 1'b0;
    repeat (3) applyStimulus();

    // Random traffic on a narrow address window so reads see earlier writes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9, 0) == 0) bus.hold = ~bus.hold;
      bus.cpu_ba    = ($urandom_range(1, 0) == 1);
      bus.vramcs    = ($urandom_range(2, 0) == 0);
      bus.dma_we    = ($urandom_range(1, 0) == 1);
      bus.dma_addr  = {8'h12, 8'($urandom)};
      bus.dma_wdata = 8'($urandom);
      bus.cpu_vma   = ($urandom_range(1, 0) == 1);
      bus.cpu_rw    = ($urandom_range(1, 0) == 1);
      bus.cpu_addr  = {8'h12, 8'($urandom)};
      bus.cpu_wdata = 8'($urandom);
      applyStimulus();
    end
    bus.hold    = 1'b0;
    bus.vramcs  = 1'b0;
    bus.dma_we  = 1'b0;
    bus.cpu_vma = 1'b0;
    repeat (4) applyStimulus();

    // Asynchronous reset in the middle of a grant
    bus.hold   = 1'b1;
    bus.cpu_ba = 1'b1;
    lat = 0;
    do begin
      applyStimulus();
      lat++;
    end while (bus.hold_ack !== 1'b1 && lat < 20);
    checkOutput("pre_rst_grant", bus.hold_ack, 1'b1);
    bus.vramcs = 1'b1;
    bus.dma_we = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_hold_ack", bus.hold_ack, 1'b0);
    checkOutput("arst_cpu_halt", bus.cpu_halt, 1'b0);
    checkOutput("arst_mem_we", bus.mem_we, 1'b0);
    checkOutput("arst_mem_ce", bus.mem_ce, 1'b0);
    checkOutput("arst_dma_err", bus.dma_err, 1'b0);
    bus.vramcs = 1'b0;
    bus.dma_we = 1'b0;
    bus.hold   = 1'b0;
    bus.cpu_ba = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("post_rst_halt", bus.cpu_halt, 1'b0);
    checkOutput("post_rst_ack", bus.hold_ack, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vram_bus_arbiter.md
# vram_bus_arbiter

Memory-side responder for the video DMA hold/vramcs protocol. It owns the shared 64 KB memory bus between the CPU and the video DMA master. It grants the bus by halting the CPU at a safe boundary and steers the memory address, data and strobes to whichever side owns the bus. It sits between the CPU core, the video DMA master and the external asynchronous-read SRAM.

## Interface
Parameters:
- BA_TIMEOUT, 4: cycles to wait for cpu_ba after halt request before a forced grant.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- hold  in  1  DMA bus request (level)
- vramcs  in  1  DMA memory access strobe
- dma_addr  in  16  DMA address (VADDR)
- dma_wdata  in  8  DMA write data (reserved for future writer)
- dma_we  in  1  DMA write enable, qualified by vramcs
- dma_rdata  out  8  read data to DMA (VDATA)
- hold_ack  out  1  bus granted to DMA
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rw  in  1  1 = read, 0 = write
- cpu_vma  in  1  CPU valid memory access
- cpu_ba  in  1  CPU bus available (halted)
- cpu_halt  out  1  halt request to CPU
- cpu_rdata  out  8  read data to CPU
- mem_addr  out  16  SRAM address
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data, combinational
- mem_we  out  1  SRAM write strobe
- mem_ce  out  1  SRAM chip enable
- dma_err  out  1  sticky: DMA access before grant completed

## Operation
FSM states: IDLE, HALT_REQ, GRANT, RELEASE.
- IDLE: mux = CPU, cpu_halt = 0, hold_ack = 0. Goes to HALT_REQ when hold = 1.
- HALT_REQ: cpu_halt = 1. Goes to GRANT when cpu_ba = 1, or when the wait counter reaches BA_TIMEOUT (forced grant). If hold drops, goes to RELEASE.
- GRANT: mux = DMA, hold_ack = 1, cpu_halt = 1. Goes to RELEASE when hold = 0.
- RELEASE: mux = CPU, hold_ack = 0, cpu_halt = 1 for this single cycle. Then goes to IDLE.

Bus steering (mux is a registered select, not combinational on hold):
- CPU side: mem_addr = cpu_addr; mem_ce = cpu_vma; mem_we = cpu_vma & ~cpu_rw; cpu_rdata = mem_rdata.
- DMA side: mem_addr = dma_addr; mem_ce = vramcs; mem_we = vramcs & dma_we; dma_rdata = mem_rdata.
- dma_rdata = 8'hFF whenever mux is not DMA.
- cpu_rdata = 8'hFF whenever mux is DMA.

Wait counter: 3 bits. Cleared on entry to HALT_REQ, increments each HALT_REQ cycle, saturates.

dma_err: set when vramcs = 1 while state is not GRANT. Cleared only by reset. An access flagged this way returns 8'hFF to the DMA and never reaches the SRAM.

Reset (rst low, asynchronous) forces:
- state = IDLE, mux = CPU, wait counter = 0
- cpu_halt = 0, hold_ack = 0, dma_err = 0
- mem_we = 0, mem_ce = 0 (outputs gated by the reset state)

## Timing
- Grant latency: hold rises at edge N → cpu_halt = 1 after edge N+1. With cpu_ba already high at N+1, hold_ack = 1 and mux = DMA after edge N+2.
  - The DMA master asserts vramcs no earlier than 2 cycles after hold, so grant must complete within 2 cycles when the CPU halts promptly.
- Forced grant: cpu_ba never rises → GRANT is entered after BA_TIMEOUT cycles in HALT_REQ.
- Reads are combinational through the mux: dma_rdata is valid in the same cycle as vramcs and dma_addr; the master samples it on the next edge.
- Writes: mem_we is asserted for every cycle that vramcs & dma_we is high. The DMA side is responsible for single-cycle strobes.
- Release: hold falls at edge M → RELEASE after M+1 (mux back to CPU) → IDLE and cpu_halt = 0 after M+2. The CPU never sees a cycle where its address drives the SRAM while halted mid-switch.
- hold re-asserted while in RELEASE: the FSM still passes through IDLE (one cycle) before HALT_REQ.
- vramcs = 1 in RELEASE: counts as an error, same as any vramcs outside GRANT.

## Test plan
- Basic grant: cpu_ba tied to cpu_halt delayed 1 cycle, hold ↑ → hold_ack = 1 exactly 2 cycles later; mem_addr follows dma_addr = 16'h4000.
- DMA burst: 64 reads, SRAM preloaded with addr[7:0] → dma_rdata equals the low address byte on every vramcs cycle; mem_we = 0 throughout; dma_err = 0.
- Timeout: cpu_ba held 0, hold ↑ → GRANT after 4 HALT_REQ cycles.
- Early access: vramcs pulsed during HALT_REQ → dma_err = 1 and sticky; dma_rdata = 8'hFF; mem_ce = 0 that cycle.
- Release and CPU resume: hold ↓ → cpu_halt = 0 two cycles later. A subsequent CPU write of 8'hA5 to 16'h1234 → mem_we = 1 with that address and data. A CPU read of the same address returns 8'hA5.
- Async reset mid-GRANT: rst low between edges → hold_ack, cpu_halt, mem_we, dma_err = 0 immediately; state = IDLE after release of reset.
